// File: rtl/valve_step_sequencer.sv
// valve_step_sequencer: plays a table of timed valve patterns on a 1 ms prescaled time base
module valve_step_sequencer #(
    parameter int NUM_VALVES = 8,
    parameter int DEPTH      = 16,
    parameter int DUR_W      = 16,
    parameter int LOOP_W     = 8,
    parameter int TICK_DIV   = 100000,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_100mega,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [NUM_VALVES-1:0] cfg_valves,
    input  logic [DUR_W-1:0]      cfg_dur,
    input  logic [AW:0]           num_steps,
    input  logic [LOOP_W-1:0]     loops,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [AW-1:0]         step_idx,
    output logic [NUM_VALVES-1:0] valves,
    output logic                  tick_1ms
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [NUM_VALVES-1:0] tbl_v [DEPTH];
    logic [DUR_W-1:0]      tbl_d [DEPTH];
    logic [PW-1:0]         pre;
    logic [PW-1:0]         pre_nxt;
    logic [DUR_W-1:0]      remaining;
    logic [AW:0]           steps_l;
    logic [LOOP_W-1:0]     loops_l;
    logic [LOOP_W-1:0]     passes;
    logic [AW-1:0]         nxt_idx;
    logic                  accept;
    logic                  last;

    function automatic logic [DUR_W-1:0] dmax(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    // start acceptance, end-of-pass detection and prescaler next value
    always_comb begin
        accept  = (state == IDLE) && start && !abort && (num_steps != '0) && (num_steps <= DEPTH_V);
        last    = ({1'b0, step_idx} == steps_l - (AW + 1)'(1));
        nxt_idx = step_idx + AW'(1);
        pre_nxt = accept ? '0 : ((pre == PRE_MAX) ? '0 : pre + PW'(1));
    end

    // step table storage; frozen while a sequence is playing
    always_ff @(posedge clk_100mega) begin
        if (cfg_we && state == IDLE) begin
            tbl_v[cfg_addr] <= cfg_valves;
            tbl_d[cfg_addr] <= cfg_dur;
        end
    end

    // sequencer FSM with prescaler and registered outputs
    always_ff @(posedge clk_100mega or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pre       <= '0;
            tick_1ms  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            step_idx  <= '0;
            valves    <= '0;
            remaining <= '0;
            steps_l   <= '0;
            loops_l   <= '0;
            passes    <= '0;
        end else begin
            pre      <= pre_nxt;
            tick_1ms <= (pre_nxt == PRE_MAX);
            done     <= 1'b0;
            err      <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    step_idx  <= '0;
                    valves    <= tbl_v[0];
                    remaining <= dmax(tbl_d[0]);
                    steps_l   <= num_steps;
                    loops_l   <= loops;
                    passes    <= loops;
                end else if (start && !abort) begin
                    err <= 1'b1;
                end
            end else if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                step_idx <= '0;
                valves   <= '0;
            end else if (tick_1ms) begin
                if (remaining > DUR_W'(1)) begin
                    remaining <= remaining - DUR_W'(1);
                end else if (!last) begin
                    step_idx  <= nxt_idx;
                    valves    <= tbl_v[nxt_idx];
                    remaining <= dmax(tbl_d[nxt_idx]);
                end else if (loops_l == '0 || passes > LOOP_W'(1)) begin
                    passes    <= (loops_l == '0) ? passes : passes - LOOP_W'(1);
                    step_idx  <= '0;
                    valves    <= tbl_v[0];
                    remaining <= dmax(tbl_d[0]);
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    step_idx  <= '0;
                    valves    <= '0;
                    passes    <= '0;
                    remaining <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_valve_step_sequencer.sv
// tb_valve_step_sequencer: randomized self-checking bench against a per-cycle expected-pattern model
module tb_valve_step_sequencer;
    localparam int TD = 10;

    logic       clk_100mega = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_valves = '0;
    logic [15:0] cfg_dur = '0;
    logic [4:0] num_steps = '0;
    logic [7:0] loops = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err, tick_1ms;
    logic [3:0] step_idx;
    logic [7:0] valves;

    logic [7:0]  m_v [16];
    logic [15:0] m_d [16];
    int n_cmp = 0;
    int n_fail = 0;

    valve_step_sequencer #(.TICK_DIV(TD)) dut (
        .clk_100mega(clk_100mega), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_valves(cfg_valves), .cfg_dur(cfg_dur), .num_steps(num_steps), .loops(loops),
        .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
        .step_idx(step_idx), .valves(valves), .tick_1ms(tick_1ms)
    );

    always #5 clk_100mega = ~clk_100mega;

    task automatic cyc();
        @(posedge clk_100mega);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] v, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_valves = v; cfg_dur = d;
        cyc();
        cfg_we = 1'b0;
        m_v[a] = v; m_d[a] = d;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || valves !== 8'h00 || step_idx !== 4'h0 || tick_1ms !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy=%b done=%b err=%b valves=%h idx=%0d tick=%b, required all 0", busy, done, err, valves, step_idx, tick_1ms);
        end
        #7 rst = 1'b1;
        cyc();
    endtask

    task automatic run_seq(input string name, input int ns, input int lp, input bit noise);
        logic [7:0] ev[$];
        logic [3:0] ei[$];
        int len;
        for (int p = 0; p < lp; p++)
            for (int s = 0; s < ns; s++)
                for (int c = 0; c < ((m_d[s] == 0) ? 1 : int'(m_d[s])) * TD; c++) begin
                    ev.push_back(m_v[s]);
                    ei.push_back(4'(s));
                end
        len = ev.size();
        num_steps = 5'(ns); loops = 8'(lp); start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            n_cmp++;
            if (valves !== ev[k] || step_idx !== ei[k] || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || tick_1ms !== ((k % TD) == TD - 1)) begin
                n_fail++;
                $display("FAIL %s cyc %0d: valves=%h idx=%0d busy=%b done=%b err=%b tick=%b, required valves=%h idx=%0d busy=1 done=0 err=0 tick=%b",
                         name, k, valves, step_idx, busy, done, err, tick_1ms, ev[k], ei[k], ((k % TD) == TD - 1));
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1)); cfg_we = 1'($urandom_range(0, 1));
                cfg_addr = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                cfg_valves = 8'($urandom); cfg_dur = 16'($urandom);
            end
            cyc();
        end
        start = 1'b0; cfg_we = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || valves !== 8'h00 || step_idx !== 4'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: done=%b busy=%b valves=%h idx=%0d err=%b, required done=1 busy=0 valves=00 idx=0 err=0", name, done, busy, valves, step_idx, err);
        end
        cyc();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_directed();
        wr(0, 8'h01, 16'd2);
        wr(1, 8'h02, 16'd1);
        wr(2, 8'h04, 16'd0);
        run_seq("directed", 3, 1, 1'b0);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 16; a++) wr(a, 8'($urandom), 16'($urandom_range(0, 3)));
            run_seq("random", $urandom_range(1, 4), $urandom_range(1, 3), r[0]);
        end
        for (int a = 0; a < 16; a++) wr(a, 8'($urandom), 16'($urandom_range(0, 1)));
        run_seq("full_depth", 16, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        wr(0, 8'hA5, 16'd1);
        wr(1, 8'h5A, 16'd2);
        run_seq("loops2_we", 2, 2, 1'b1);
        run_seq("table_kept", 2, 1, 1'b0);
    endtask

    task automatic test_loop_abort();
        logic [7:0] ev[$];
        logic [3:0] ei[$];
        int m;
        wr(0, 8'h01, 16'd2);
        wr(1, 8'h02, 16'd1);
        wr(2, 8'h04, 16'd0);
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < ((m_d[s] == 0) ? 1 : int'(m_d[s])) * TD; c++) begin
                ev.push_back(m_v[s]);
                ei.push_back(4'(s));
            end
        m = $urandom_range(90, 200);
        num_steps = 5'd3; loops = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < m; k++) begin
            n_cmp++;
            if (valves !== ev[k % ev.size()] || step_idx !== ei[k % ei.size()] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL infinite cyc %0d: valves=%h idx=%0d busy=%b done=%b, required valves=%h idx=%0d busy=1 done=0",
                         k, valves, step_idx, busy, done, ev[k % ev.size()], ei[k % ei.size()]);
            end
            cyc();
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (valves !== 8'h00 || busy !== 1'b0 || step_idx !== 4'h0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort cyc %0d: valves=%h busy=%b idx=%0d done=%b, required 00 0 0 0", k, valves, busy, step_idx, done);
            end
            cyc();
        end
    endtask

    task automatic test_err();
        logic [4:0] bad [3];
        bad[0] = 5'd0; bad[1] = 5'd17; bad[2] = 5'($urandom_range(18, 31));
        for (int i = 0; i < 3; i++) begin
            num_steps = bad[i]; loops = 8'd1; start = 1'b1;
            cyc();
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || busy !== 1'b0 || valves !== 8'h00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL err n=%0d: err=%b busy=%b valves=%h done=%b, required 1 0 00 0", bad[i], err, busy, valves, done);
            end
            cyc();
            n_cmp++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse n=%0d: err=%b busy=%b, required 0 0", bad[i], err, busy);
            end
        end
    endtask

    task automatic test_start_abort();
        logic [4:0] ns [2];
        ns[0] = 5'd2; ns[1] = 5'd0;
        for (int i = 0; i < 2; i++) begin
            num_steps = ns[i]; loops = 8'd1; start = 1'b1; abort = 1'b1;
            cyc();
            start = 1'b0; abort = 1'b0;
            n_cmp++;
            if (busy !== 1'b0 || err !== 1'b0 || valves !== 8'h00) begin
                n_fail++;
                $display("FAIL start_abort n=%0d: busy=%b err=%b valves=%h, required 0 0 00", ns[i], busy, err, valves);
            end
            cyc();
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        wr(0, 8'hF0, 16'd3);
        num_steps = 5'd1; loops = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (15) cyc();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (valves !== 8'h00 || busy !== 1'b0 || step_idx !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: valves=%h busy=%b idx=%0d, required 00 0 0", valves, busy, step_idx);
        end
        #2 rst = 1'b1;
        cnt = 0;
        while (cnt < 25 && tick_1ms !== 1'b1) begin
            cyc();
            cnt++;
        end
        n_cmp++;
        if (cnt < 9 || cnt > 10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_after_reset: first tick after %0d clk busy=%b, required 9..10 clk busy=0", cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_runs();
        test_back_to_back();
        test_loop_abort();
        test_err();
        test_start_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
